// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcode encodings, ALU op
// constants and the packed control word carried from ID into EX.
package pipe_ctrl_pkg;

    localparam logic [7:0] OP_ADD  = 8'h08;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_MOV  = 8'h1A;
    localparam logic [7:0] OP_ADDI = 8'h28;
    localparam logic [7:0] OP_SUBI = 8'h24;
    localparam logic [7:0] OP_MOVI = 8'h3A;
    localparam logic [7:0] OP_LDR  = 8'h51;
    localparam logic [7:0] OP_LDR2 = 8'h59;
    localparam logic [7:0] OP_STR  = 8'h50;
    localparam logic [7:0] OP_CMP  = 8'h15;
    localparam logic [7:0] OP_CMPI = 8'h35;
    localparam logic [7:0] OP_B    = 8'hA0;  // unconditional, forward
    localparam logic [7:0] OP_BN   = 8'hA1;  // unconditional, backward
    localparam logic [7:0] OP_BGE  = 8'hB0;
    localparam logic [7:0] OP_BLE  = 8'hB1;

    localparam logic [1:0] ALU_MEM = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       cmp;
        logic [1:0] aluop;
    } ctrl_word_t;

    function automatic ctrl_word_t mk_ctrl(input logic r2l, input logic asrc, input logic m2r,
                                           input logic rw, input logic mr, input logic mw,
                                           input logic c, input logic [1:0] aop);
        ctrl_word_t w;
        w.reg2loc  = r2l;
        w.alusrc   = asrc;
        w.memtoreg = m2r;
        w.regwrite = rw;
        w.memread  = mr;
        w.memwrite = mw;
        w.cmp      = c;
        w.aluop    = aop;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ctrl_decode: purely combinational opcode decode.
//   opcode    : ID opcode (upper bits above 8 must be zero for a legal op)
//   ctrl      : control word, all zeros for illegal opcodes
//   uses_rs1  : instruction reads rs1
//   uses_rs2  : instruction reads rs2
//   is_branch : A0/A1/B0/B1
//   illegal   : opcode not in the instruction set
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 8
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          ctrl,
    output logic                uses_rs1,
    output logic                uses_rs2,
    output logic                is_branch,
    output logic                illegal
);

    logic [OPCODE_W-1:0] hi_bits;
    logic [7:0]          op8;
    logic                legal;

    assign hi_bits = opcode & ~OPCODE_W'(8'hFF);
    assign op8     = opcode[7:0];

    always_comb begin
        ctrl      = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        is_branch = 1'b0;
        legal     = 1'b1;
        case (op8)
            OP_ADD, OP_SUB: begin
                ctrl     = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_R);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_MOV: begin
                ctrl     = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_R);
                uses_rs2 = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                ctrl     = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_R);
                uses_rs1 = 1'b1;
            end
            OP_MOVI: begin
                ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALU_R);
            end
            OP_LDR, OP_LDR2: begin
                ctrl     = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_MEM);
                uses_rs1 = 1'b1;
            end
            OP_STR: begin
                ctrl     = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_MEM);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_CMP: begin
                ctrl     = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_CMP);
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_CMPI: begin
                ctrl     = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_CMP);
                uses_rs1 = 1'b1;
            end
            OP_B, OP_BN, OP_BGE, OP_BLE: begin
                ctrl      = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_CMP);
                is_branch = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Any bit above the 8-bit encoding space makes the opcode illegal.
        if (hi_bits != '0) begin
            ctrl      = '0;
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
            is_branch = 1'b0;
            legal     = 1'b0;
        end
    end

    assign illegal = ~legal;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control unit for the stalling 5-stage pipeline.
//   clk, reset            : clock, asynchronous active-high reset
//   id_*_i                : instruction currently in ID
//   ex_lt_i / ex_eq_i     : live compare result of the EX instruction
//   ex_*_o                : registered ID/EX control word and destination
//   stall_o / flush_o     : load-use hold, branch kill of IF/ID
//   take_branch_o         : PC redirect; branch_pos_o gives offset sign
//   illegal_cnt_o         : saturating count of issued illegal opcodes
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 8,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_i,
    input  logic [OPCODE_W-1:0]   id_opcode_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  ex_lt_i,
    input  logic                  ex_eq_i,
    output logic                  ex_valid_o,
    output logic                  ex_reg2loc_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_memtoreg_o,
    output logic                  ex_regwrite_o,
    output logic                  ex_memread_o,
    output logic                  ex_memwrite_o,
    output logic                  ex_cmp_o,
    output logic [1:0]            ex_aluop_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  take_branch_o,
    output logic                  branch_pos_o,
    output logic [CNT_W-1:0]      illegal_cnt_o
);

    ctrl_word_t            id_ctrl;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  id_is_branch;
    logic                  id_illegal;

    ctrl_word_t            ex_ctrl_q;
    logic                  ex_valid_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  lt_q;
    logic                  eq_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  stall;
    logic                  issue;
    logic                  ex_cmp_fwd;
    logic                  lt_eff;
    logic                  eq_eff;
    logic                  take;
    logic                  pos;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode    (id_opcode_i),
        .ctrl      (id_ctrl),
        .uses_rs1  (id_uses_rs1),
        .uses_rs2  (id_uses_rs2),
        .is_branch (id_is_branch),
        .illegal   (id_illegal)
    );

    assign stall = id_valid_i & ex_valid_q & ex_ctrl_q.memread &
                   ((id_uses_rs1 & (id_rs1_i == ex_rd_q)) |
                    (id_uses_rs2 & (id_rs2_i == ex_rd_q)));
    assign issue = id_valid_i & ~stall;

    // Forward the live compare result so a branch right behind CMP needs no stall.
    assign ex_cmp_fwd = ex_valid_q & ex_ctrl_q.cmp;
    assign lt_eff     = ex_cmp_fwd ? ex_lt_i : lt_q;
    assign eq_eff     = ex_cmp_fwd ? ex_eq_i : eq_q;

    always_comb begin
        take = 1'b0;
        pos  = 1'b1;
        // issue already excludes stall, so a stalled cycle can never redirect.
        if (issue && id_is_branch) begin
            case (id_opcode_i[7:0])
                OP_B:    take = 1'b1;
                OP_BN: begin
                    take = 1'b1;
                    pos  = 1'b0;
                end
                OP_BGE:  take = ~lt_eff;
                OP_BLE:  take = lt_eff | eq_eff;
                default: take = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_rd_q    <= '0;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (issue) begin
                ex_valid_q <= 1'b1;
                ex_ctrl_q  <= id_ctrl;
                ex_rd_q    <= id_rd_i;
            end else begin
                ex_valid_q <= 1'b0;
                ex_ctrl_q  <= '0;
                ex_rd_q    <= '0;
            end
            if (ex_cmp_fwd) begin
                lt_q <= ex_lt_i;
                eq_q <= ex_eq_i;
            end
            if (issue && id_illegal && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_reg2loc_o  = ex_ctrl_q.reg2loc;
    assign ex_alusrc_o   = ex_ctrl_q.alusrc;
    assign ex_memtoreg_o = ex_ctrl_q.memtoreg;
    assign ex_regwrite_o = ex_ctrl_q.regwrite;
    assign ex_memread_o  = ex_ctrl_q.memread;
    assign ex_memwrite_o = ex_ctrl_q.memwrite;
    assign ex_cmp_o      = ex_ctrl_q.cmp;
    assign ex_aluop_o    = ex_ctrl_q.aluop;
    assign ex_rd_o       = ex_rd_q;
    assign stall_o       = stall;
    assign flush_o       = take;
    assign take_branch_o = take;
    assign branch_pos_o  = pos;
    assign illegal_cnt_o = cnt_q;

endmodule
